// File: rtl/mult_booth_iter_if.sv
// Operand/result handshake bundle for mult_booth_iter.
// master: the requester (multdiv wrapper or bench); slave: the multiplier.
interface mult_booth_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   result_valid;
    logic                   result_ready;
    logic                   ovf;

    modport master (
        output start, is_signed, multiplicand, multiplier, result_ready,
        input  in_ready, result, result_valid, ovf
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier, result_ready,
        output in_ready, result, result_valid, ovf
    );
endinterface

// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit (two multiplier bits)
// per clock, N = WIDTH/2+1 steps, with an operand/result handshake.
// Optional feature macro: MULT_BOOTH_OVF_EN (computes the ovf flag; when
// undefined the ovf port is tied low and no compare logic exists).
//
// Product register layout (2*WIDTH+6 bits):
//   [PW-1 : BW+1]  ACC, WIDTH+3 bits, room for +/-2*Ax
//   [BW   : 1]     Bx, multiplier extended by two bits
//   [0]            q, the Booth look-behind bit
module mult_booth_iter #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              resetn,
    mult_booth_iter_if.slave  bus
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int AW = WIDTH + 3;
    localparam int BW = WIDTH + 2;
    localparam int PW = AW + BW + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        p_q, p_d;
    logic [AW-1:0]        ax_q, ax_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 valid_q, valid_d;

    logic                 in_ready;
    logic                 accept;
    logic                 enter_done;
    logic [AW-1:0]        ax_load;
    logic [BW-1:0]        bx_load;
    logic [AW-1:0]        digit;
    logic [AW-1:0]        acc_sum;
    logic [PW-1:0]        p_step;
    logic [2*WIDTH-1:0]   product_fin;

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.result_ready);
    assign accept     = bus.start && in_ready;
    assign enter_done = (state_q == S_RUN) && (count_q == CW'(N - 1));

    // Operand extension: sign bit replicated in signed mode, zeros otherwise.
    assign ax_load = bus.is_signed ? {{3{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                   : {3'b000, bus.multiplicand};
    assign bx_load = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                   : {2'b00, bus.multiplier};

    // One Booth step: recode {b1,b0,q}, add to ACC, then shift right by two arithmetically.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        digit = '0;
        case (p_q[2:0])
            3'b001, 3'b010: digit = ax_q;
            3'b011:         digit = ax_q << 1;
            3'b100:         digit = -(ax_q << 1);
            3'b101, 3'b110: digit = -ax_q;
            default:        digit = '0;
        endcase
        acc_sum     = p_q[PW-1:BW+1] + digit;
        p_step      = $signed({acc_sum, p_q[BW:0]}) >>> 2;
        product_fin = p_step[2*WIDTH:1];
    end

    // Iteration FSM: next state, product register, counter and result capture.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        ax_d     = ax_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                p_d     = p_step;
                count_d = count_q + CW'(1);
                if (enter_done) begin
                    state_d  = S_DONE;
                    result_d = product_fin;
                    valid_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.result_ready) begin
                    valid_d = 1'b0;
                    state_d = accept ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operand load, shared by the IDLE accept and the back-to-back DONE accept.
        if (accept) begin
            p_d     = {{AW{1'b0}}, bx_load, 1'b0};
            ax_d    = ax_load;
            count_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            ax_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            p_q      <= p_d;
            ax_q     <= ax_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;

`ifdef MULT_BOOTH_OVF_EN
    logic signed_q, signed_d;
    logic ovf_q, ovf_d;
    logic ovf_calc;

    // Overflow: product not representable in WIDTH bits for the latched mode.
    always_comb begin
        signed_d = signed_q;
        ovf_d    = ovf_q;
        ovf_calc = 1'b0;
        if (signed_q)
            ovf_calc = !(&product_fin[2*WIDTH-1:WIDTH-1]) && (|product_fin[2*WIDTH-1:WIDTH-1]);
        else
            ovf_calc = |product_fin[2*WIDTH-1:WIDTH];
        if (accept)     signed_d = bus.is_signed;
        if (enter_done) ovf_d    = ovf_calc;
    end

    // Mode and overflow flag registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            signed_q <= signed_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule
